packet_serializer: RTL and testbench

- Consumer end of the queues-to-serializer interface of the queueing domain.
- Takes one queue grant (core id) from the scheduler and issues a single-cycle pop request (ready pulse) to the queueing domain.
- Captures the returned DATA_SIZE-bit packet on its one-cycle valid pulse.
- Streams the packet downstream as ceil(DATA_SIZE/BEAT_WIDTH) beats over a valid/ready/last interface.

---
 rtl/memoredf_pkg.sv | 16 +
 rtl/packet_beat_shifter.sv | 47 ++++
 rtl/packet_serializer.sv | 131 +++++++++++++
 tb/tb_packet_serializer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memoredf_pkg.sv
// Shared types and sizing helpers for the queue-to-serializer consumer path.
package memoredf_pkg;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, SEND} state_t;

    function automatic int unsigned num_beats(input int unsigned data_size,
                                              input int unsigned beat_width);
        return (data_size + beat_width - 1) / beat_width;
    endfunction

    // Counter/index width for a range of `count` values, never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/packet_beat_shifter.sv
// Zero-padded packet shift register that hands out one beat at a time, LSB beat first.
module packet_beat_shifter
    import memoredf_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 678,
    parameter int unsigned BEAT_WIDTH = 128
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [DATA_SIZE-1:0]  i_packet,
    input  logic                  i_shift,
    output logic [BEAT_WIDTH-1:0] o_data,
    output logic                  o_last
);

    localparam int unsigned NumBeats = num_beats(DATA_SIZE, BEAT_WIDTH);
    localparam int unsigned PadWidth = NumBeats * BEAT_WIDTH;
    localparam int unsigned CntWidth = width_for(NumBeats);

    logic [PadWidth-1:0] r_shift;
    logic [CntWidth-1:0] r_beat_cnt;
    logic [PadWidth-1:0] w_padded;

    // Register spans whole beats so the final beat's MSBs come out as zeros.
    always_comb begin
        w_padded                = '0;
        w_padded[DATA_SIZE-1:0] = i_packet;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_beat_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= w_padded;
            r_beat_cnt <= '0;
        end else if (i_shift) begin
            r_shift    <= r_shift >> BEAT_WIDTH;
            r_beat_cnt <= r_beat_cnt + CntWidth'(1);
        end
    end

    assign o_data = r_shift[BEAT_WIDTH-1:0];
    assign o_last = (r_beat_cnt == CntWidth'(NumBeats - 1));

endmodule

// File: rtl/packet_serializer.sv
// Serves one scheduler grant: pops the granted queue once, waits for the packet,
// then streams it downstream as valid/ready/last beats.
module packet_serializer
    import memoredf_pkg::*;
#(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned DATA_SIZE        = 678,
    parameter int unsigned BEAT_WIDTH       = 128,
    parameter int unsigned RESP_TIMEOUT     = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   sched_grant_valid,
    input  logic [width_for(NUMBER_OF_QUEUES)-1:0] sched_grant_core_id,
    output logic                                   sched_grant_ready,
    input  logic [NUMBER_OF_QUEUES-1:0]            queues_empty,
    output logic                                   grant_dropped,
    output logic                                   scheduler_to_queues_ready,
    output logic [width_for(NUMBER_OF_QUEUES)-1:0] core_id,
    input  logic                                   queues_to_serializer_valid,
    input  logic [DATA_SIZE-1:0]                   queues_to_serializer_packet,
    output logic [BEAT_WIDTH-1:0]                  m_data,
    output logic                                   m_valid,
    output logic                                   m_last,
    output logic [width_for(NUMBER_OF_QUEUES)-1:0] m_core_id,
    input  logic                                   m_ready,
    output logic                                   busy,
    output logic                                   timeout_error
);

    localparam int unsigned IdWidth   = width_for(NUMBER_OF_QUEUES);
    localparam int unsigned WaitWidth = width_for(RESP_TIMEOUT);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IdWidth-1:0]      r_core_id;
    logic [WaitWidth-1:0]    r_wait_cnt;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_last;
    logic [BEAT_WIDTH-1:0]   w_beat;

    packet_beat_shifter #(
        .DATA_SIZE  (DATA_SIZE),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_shifter (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_load   (w_load),
        .i_packet (queues_to_serializer_packet),
        .i_shift  (w_shift),
        .o_data   (w_beat),
        .o_last   (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_core_id  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && sched_grant_valid) begin
                r_core_id <= sched_grant_core_id;
            end
            if (r_state == REQUEST) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WaitWidth'(1);
            end
        end
    end

    always_comb begin
        w_next_state              = r_state;
        sched_grant_ready         = 1'b0;
        grant_dropped             = 1'b0;
        scheduler_to_queues_ready = 1'b0;
        timeout_error             = 1'b0;
        m_valid                   = 1'b0;
        m_last                    = 1'b0;
        m_data                    = '0;
        m_core_id                 = '0;
        w_load                    = 1'b0;
        w_shift                   = 1'b0;
        unique case (r_state)
            IDLE: begin
                sched_grant_ready = 1'b1;
                if (sched_grant_valid) begin
                    if (queues_empty[sched_grant_core_id]) begin
                        grant_dropped = 1'b1;
                    end else begin
                        w_next_state = REQUEST;
                    end
                end
            end
            REQUEST: begin
                // Single-cycle pop so the queue side always sees a fresh rising edge.
                scheduler_to_queues_ready = 1'b1;
                w_next_state              = WAIT;
            end
            WAIT: begin
                if (queues_to_serializer_valid) begin
                    w_load       = 1'b1;
                    w_next_state = SEND;
                end else if (r_wait_cnt == WaitWidth'(RESP_TIMEOUT - 1)) begin
                    timeout_error = 1'b1;
                    w_next_state  = IDLE;
                end
            end
            SEND: begin
                m_valid   = 1'b1;
                m_data    = w_beat;
                m_last    = w_last;
                m_core_id = r_core_id;
                if (m_ready) begin
                    if (w_last) begin
                        w_next_state = IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign core_id = r_core_id;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_packet_serializer.sv
// Self-checking bench: table vectors, random transactions and reset/back-to-back sequences.
module tb_packet_serializer;

    localparam int unsigned NQ = 4;
    localparam int unsigned DS = 678;
    localparam int unsigned BW = 128;
    localparam int unsigned RT = 16;
    localparam int unsigned NB = (DS + BW - 1) / BW;

    logic              clock = 1'b0;
    logic              reset;
    logic              sched_grant_valid;
    logic [1:0]        sched_grant_core_id;
    logic              sched_grant_ready;
    logic [NQ-1:0]     queues_empty;
    logic              grant_dropped;
    logic              scheduler_to_queues_ready;
    logic [1:0]        core_id;
    logic              queues_to_serializer_valid;
    logic [DS-1:0]     queues_to_serializer_packet;
    logic [BW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic [1:0]        m_core_id;
    logic              m_ready;
    logic              busy;
    logic              timeout_error;

    packet_serializer #(
        .NUMBER_OF_QUEUES (NQ),
        .DATA_SIZE        (DS),
        .BEAT_WIDTH       (BW),
        .RESP_TIMEOUT     (RT)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .sched_grant_valid           (sched_grant_valid),
        .sched_grant_core_id         (sched_grant_core_id),
        .sched_grant_ready           (sched_grant_ready),
        .queues_empty                (queues_empty),
        .grant_dropped               (grant_dropped),
        .scheduler_to_queues_ready   (scheduler_to_queues_ready),
        .core_id                     (core_id),
        .queues_to_serializer_valid  (queues_to_serializer_valid),
        .queues_to_serializer_packet (queues_to_serializer_packet),
        .m_data                      (m_data),
        .m_valid                     (m_valid),
        .m_last                      (m_last),
        .m_core_id                   (m_core_id),
        .m_ready                     (m_ready),
        .busy                        (busy),
        .timeout_error               (timeout_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor logs, sampled on the falling edge.
    int            ready_q[$];
    int            ready_core_q[$];
    int            drop_q[$];
    int            to_q[$];
    logic [BW-1:0] beat_q[$];
    logic          last_q[$];
    int            mcore_q[$];
    int            hs_q[$];
    int            valid_cycles;
    logic          p_hold = 1'b0;
    logic [BW-1:0] p_data;
    logic          p_last;

    always @(negedge clock) begin
        if (!reset) begin
            if (scheduler_to_queues_ready) begin
                ready_q.push_back(cyc);
                ready_core_q.push_back(int'(core_id));
            end
            if (grant_dropped) drop_q.push_back(cyc);
            if (timeout_error) to_q.push_back(cyc);
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                mcore_q.push_back(int'(m_core_id));
                hs_q.push_back(cyc);
            end
            if (p_hold) begin
                chk("hold.valid", BW'(m_valid), BW'(1));
                chk("hold.data", m_data, p_data);
                chk("hold.last", BW'(m_last), BW'(p_last));
            end
        end
        p_hold = m_valid && !m_ready && !reset;
        p_data = m_data;
        p_last = m_last;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        ready_q.delete();
        ready_core_q.delete();
        drop_q.delete();
        to_q.delete();
        beat_q.delete();
        last_q.delete();
        mcore_q.delete();
        hs_q.delete();
        valid_cycles = 0;
    endtask

    function automatic logic [DS-1:0] make_packet(input int kind);
        logic [DS-1:0] p;
        logic [7:0]    bv;
        p = '0;
        for (int i = 0; i < int'(DS); i++) begin
            bv = 8'(i / 8);
            case (kind)
                0:       p[i] = bv[i % 8];
                1:       p[i] = 1'b1;
                default: p[i] = 1'($urandom_range(0, 1));
            endcase
        end
        return p;
    endfunction

    // Reference: beat k is the k-th BW-bit slice of the packet zero-extended to whole beats.
    function automatic logic [BW-1:0] ref_beat(input logic [DS-1:0] p, input int k);
        logic [NB*BW-1:0] ext;
        ext = '0;
        ext[DS-1:0] = p;
        return ext[k*BW +: BW];
    endfunction

    function automatic logic bp_ready(input int bp, input int rel);
        case (bp)
            0:       return 1'b1;
            1:       return (rel % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    int last_ready_cyc = 0;

    task automatic run_txn(input string tag, input int core, input logic [NQ-1:0] empty,
                           input int delay, input logic [DS-1:0] pkt, input int bp,
                           input bit spur, input bit exp_drop, input bit exp_to,
                           input int exp_beats);
        int t;
        int pend;
        int n;
        int end_cyc;
        n = 0;
        while (!sched_grant_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk({tag, ".idle_wait"}, BW'(0), BW'(1));
        clear_logs();
        queues_empty                = empty;
        sched_grant_core_id         = 2'(core);
        sched_grant_valid           = 1'b1;
        queues_to_serializer_valid  = spur;
        queues_to_serializer_packet = make_packet(2);
        m_ready                     = 1'b1;
        t = cyc;
        step();
        sched_grant_valid   = 1'b0;
        sched_grant_core_id = 2'($urandom_range(0, 3));
        pend = -1;
        n = 0;
        while (n < 150) begin
            if (sched_grant_ready) break;
            if (scheduler_to_queues_ready) pend = cyc + 1 + delay;
            if (cyc == pend) begin
                queues_to_serializer_valid  = 1'b1;
                queues_to_serializer_packet = pkt;
            end else if (spur && pend >= 0 && cyc > pend) begin
                queues_to_serializer_valid  = 1'b1;
                queues_to_serializer_packet = make_packet(2);
            end else begin
                queues_to_serializer_valid = 1'b0;
            end
            m_ready = bp_ready(bp, cyc - t);
            step();
            n++;
        end
        queues_to_serializer_valid = 1'b0;
        m_ready = 1'b1;
        end_cyc = cyc;
        if (n >= 150) chk({tag, ".done_wait"}, BW'(0), BW'(1));

        chk({tag, ".dropped"}, BW'(drop_q.size()), BW'(exp_drop));
        if (exp_drop) begin
            chk({tag, ".no_pop"}, BW'(ready_q.size()), BW'(0));
            if (drop_q.size() > 0) chk({tag, ".drop_cyc"}, BW'(drop_q[0]), BW'(t));
            chk({tag, ".drop_core"}, BW'(core_id), BW'(core));
        end else begin
            chk({tag, ".pops"}, BW'(ready_q.size()), BW'(1));
            if (ready_q.size() > 0) begin
                chk({tag, ".pop_cyc"}, BW'(ready_q[0]), BW'(t + 1));
                chk({tag, ".pop_core"}, BW'(ready_core_q[0]), BW'(core));
                last_ready_cyc = ready_q[0];
            end
        end
        chk({tag, ".timeouts"}, BW'(to_q.size()), BW'(exp_to));
        if (exp_to) begin
            if (to_q.size() > 0) chk({tag, ".to_cyc"}, BW'(to_q[0]), BW'(t + 1 + int'(RT)));
            chk({tag, ".to_nvalid"}, BW'(valid_cycles), BW'(0));
            chk({tag, ".to_end"}, BW'(end_cyc), BW'(t + 2 + int'(RT)));
        end
        chk({tag, ".beats"}, BW'(beat_q.size()), BW'(exp_beats));
        for (int k = 0; k < beat_q.size() && k < exp_beats; k++) begin
            chk($sformatf("%s.data%0d", tag, k), beat_q[k], ref_beat(pkt, k));
            chk($sformatf("%s.last%0d", tag, k), BW'(last_q[k]), BW'(k == exp_beats - 1));
            chk($sformatf("%s.mcore%0d", tag, k), BW'(mcore_q[k]), BW'(core));
        end
        if (exp_beats > 0 && bp == 0 && hs_q.size() > 0) begin
            chk({tag, ".first_cyc"}, BW'(hs_q[0]), BW'(t + 3 + delay));
            chk({tag, ".end_cyc"}, BW'(end_cyc), BW'(t + 3 + delay + int'(NB)));
        end
    endtask

    typedef struct {
        int           core;
        logic [NQ-1:0] empty;
        int           delay;
        int           kind;
        int           bp;
        bit           spur;
        bit           exp_drop;
        bit           exp_to;
        int           exp_beats;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int core, input logic [NQ-1:0] empty, input int delay,
                           input int kind, input int bp, input bit spur, input bit exp_drop,
                           input bit exp_to, input int exp_beats);
        vec_t v;
        v.core = core; v.empty = empty; v.delay = delay; v.kind = kind; v.bp = bp;
        v.spur = spur; v.exp_drop = exp_drop; v.exp_to = exp_to; v.exp_beats = exp_beats;
        vecs.push_back(v);
    endtask

    initial begin
        int            r0;
        int            n;
        int            pend;
        int            nlast;
        logic [DS-1:0] pkt;
        int            core;
        logic [NQ-1:0] empty;
        int            delay;
        bit            drop;
        bit            to;

        reset = 1'b1;
        sched_grant_valid = 1'b0;
        sched_grant_core_id = 2'd0;
        queues_empty = '0;
        queues_to_serializer_valid = 1'b0;
        queues_to_serializer_packet = '0;
        m_ready = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        #1;
        chk("rst.grant_ready", BW'(sched_grant_ready), BW'(1));
        chk("rst.busy", BW'(busy), BW'(0));
        chk("rst.m_valid", BW'(m_valid), BW'(0));
        chk("rst.m_data", m_data, BW'(0));
        chk("rst.pop", BW'(scheduler_to_queues_ready), BW'(0));
        chk("rst.core_id", BW'(core_id), BW'(0));
        chk("rst.timeout", BW'(timeout_error), BW'(0));

        add_vec(2, 4'b0000, 0,  0, 0, 1'b0, 1'b0, 1'b0, NB);  // single packet
        add_vec(2, 4'b0000, 0,  0, 1, 1'b0, 1'b0, 1'b0, NB);  // backpressure 1,0,0
        add_vec(1, 4'b0010, 0,  0, 0, 1'b0, 1'b1, 1'b0, 0);   // empty queue
        add_vec(0, 4'b0010, 0,  0, 0, 1'b0, 1'b0, 1'b0, NB);  // served after drop
        add_vec(3, 4'b0000, 99, 0, 0, 1'b0, 1'b0, 1'b1, 0);   // no response
        add_vec(1, 4'b0000, RT - 1, 1, 0, 1'b0, 1'b0, 1'b0, NB);  // latest valid accepted
        add_vec(0, 4'b0000, RT, 1, 0, 1'b1, 1'b0, 1'b1, 0);   // one cycle too late
        add_vec(3, 4'b1111, 0,  0, 0, 1'b0, 1'b1, 1'b0, 0);
        add_vec(2, 4'b1011, 3,  2, 2, 1'b1, 1'b0, 1'b0, NB);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].core, vecs[i].empty, vecs[i].delay,
                    make_packet(vecs[i].kind), vecs[i].bp, vecs[i].spur,
                    vecs[i].exp_drop, vecs[i].exp_to, vecs[i].exp_beats);
        end

        // Spurious valid while idle must not start anything.
        queues_to_serializer_valid = 1'b1;
        queues_to_serializer_packet = make_packet(2);
        step(); step(); step();
        queues_to_serializer_valid = 1'b0;
        chk("spur.idle_busy", BW'(busy), BW'(0));
        chk("spur.idle_ready", BW'(sched_grant_ready), BW'(1));

        // Back-to-back grants with spurious valids around them.
        run_txn("b2b0", 0, 4'b0000, 0, make_packet(0), 0, 1'b1, 1'b0, 1'b0, NB);
        r0 = last_ready_cyc;
        run_txn("b2b1", 1, 4'b0000, 0, make_packet(1), 0, 1'b1, 1'b0, 1'b0, NB);
        chk("b2b.spacing", BW'(last_ready_cyc - r0), BW'(NB + 3));

        // Reset while the third beat is on the bus.
        clear_logs();
        queues_empty = '0;
        pkt = make_packet(0);
        sched_grant_core_id = 2'd2;
        sched_grant_valid = 1'b1;
        step();
        sched_grant_valid = 1'b0;
        pend = -1;
        n = 0;
        while (beat_q.size() < 2 && n < 50) begin
            if (scheduler_to_queues_ready) pend = cyc + 1;
            queues_to_serializer_valid = (cyc == pend);
            queues_to_serializer_packet = pkt;
            m_ready = 1'b1;
            step();
            n++;
        end
        queues_to_serializer_valid = 1'b0;
        chk("rstmid.reached", BW'(beat_q.size()), BW'(2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rstmid.m_valid", BW'(m_valid), BW'(0));
        chk("rstmid.grant_ready", BW'(sched_grant_ready), BW'(1));
        chk("rstmid.busy", BW'(busy), BW'(0));
        nlast = 0;
        foreach (last_q[k]) if (last_q[k]) nlast++;
        chk("rstmid.no_last", BW'(nlast), BW'(0));
        run_txn("rstmid.next", 2, 4'b0000, 1, make_packet(2), 0, 1'b0, 1'b0, 1'b0, NB);

        // Random transactions against the reference rules.
        for (int i = 0; i < 20; i++) begin
            core  = $urandom_range(0, NQ - 1);
            empty = NQ'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) empty[core] = 1'b0;
            delay = $urandom_range(0, RT + 2);
            drop  = empty[core];
            to    = !drop && (delay >= int'(RT));
            run_txn($sformatf("rnd%0d", i), core, empty, delay, make_packet(2),
                    $urandom_range(0, 2), bit'($urandom_range(0, 1)), drop, to,
                    (drop || to) ? 0 : NB);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
